// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : two-master round-robin arbiter onto one AXI4-lite slave,
//                   one transaction in flight, watchdog-fabricated responses.
// Revision 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [1:0]  m_ARvalid,
  input  logic [63:0] m_ARdata,
  input  logic [5:0]  m_arprot,
  output logic [1:0]  m_ARready,
  output logic [1:0]  m_Rvalid,
  input  logic [1:0]  m_RReady,
  output logic [31:0] m_Rdata,
  input  logic [1:0]  m_AWvalid,
  input  logic [63:0] m_AWdata,
  input  logic [5:0]  m_awprot,
  output logic [1:0]  m_AWready,
  input  logic [1:0]  m_Wvalid,
  input  logic [63:0] m_Wdata,
  input  logic [7:0]  m_Wstrb,
  output logic [1:0]  m_Wready,
  output logic [1:0]  m_Bvalid,
  input  logic [1:0]  m_Bready,

  output logic        s_ARvalid,
  output logic [31:0] s_ARdata,
  output logic [2:0]  s_arprot,
  input  logic        s_ARready,
  input  logic        s_Rvalid,
  input  logic [31:0] s_Rdata,
  output logic        s_RReady,
  output logic        s_AWvalid,
  output logic [31:0] s_AWdata,
  output logic [2:0]  s_awprot,
  input  logic        s_AWready,
  output logic        s_Wvalid,
  output logic [31:0] s_Wdata,
  output logic [3:0]  s_Wstrb,
  input  logic        s_Wready,
  input  logic        s_Bvalid,
  output logic        s_Bready,

  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned     c_wcnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_wcnt_w-1:0] c_wd_last = c_wcnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_TOUT = 2'd3
  } state_e;

  state_e                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  ar_done_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  tout_rd_q;
  logic [c_wcnt_w-1:0]   wcnt_q;
  logic [1:0]            grant_q;
  logic                  busy_q;

  logic [1:0] w_rd_req;
  logic [1:0] w_wr_req;
  logic [1:0] w_req;
  logic       w_win;
  logic       w_sel;
  logic       w_in_rd;
  logic       w_in_wr;
  logic       w_in_tout;
  logic       w_b_ok;
  logic       w_ar_hs;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_rd_cpl;
  logic       w_wr_cpl;
  logic       w_wd_hit;
  logic       w_tout_cpl;

  assign w_rd_req = m_ARvalid;
  assign w_wr_req = m_AWvalid | m_Wvalid;
  assign w_req    = w_rd_req | w_wr_req;

  // On a tie the master that did not win last time goes next.
  assign w_win = (w_req == 2'b11) ? ~last_q : w_req[1];

  assign w_sel     = owner_q;
  assign w_in_rd   = (state_q == S_RD);
  assign w_in_wr   = (state_q == S_WR);
  assign w_in_tout = (state_q == S_TOUT);
  assign w_b_ok    = aw_done_q & w_done_q;

  assign w_ar_hs  = w_in_rd & m_ARvalid[w_sel] & ~ar_done_q & s_ARready;
  assign w_aw_hs  = w_in_wr & m_AWvalid[w_sel] & ~aw_done_q & s_AWready;
  assign w_w_hs   = w_in_wr & m_Wvalid[w_sel]  & ~w_done_q  & s_Wready;
  assign w_rd_cpl = w_in_rd & s_Rvalid & m_RReady[w_sel];
  assign w_wr_cpl = w_in_wr & w_b_ok & s_Bvalid & m_Bready[w_sel];

  // A genuine completion in the last allowed cycle beats the watchdog.
  assign w_wd_hit = (TIMEOUT != 0) && (wcnt_q == c_wd_last) &&
                    (w_in_rd || w_in_wr) && !w_rd_cpl && !w_wr_cpl;

  assign w_tout_cpl = w_in_tout & (tout_rd_q ? m_RReady[w_sel] : m_Bready[w_sel]);

  assign s_ARvalid = w_in_rd & m_ARvalid[w_sel] & ~ar_done_q;
  assign s_ARdata  = w_sel ? m_ARdata[63:32] : m_ARdata[31:0];
  assign s_arprot  = w_sel ? m_arprot[5:3]   : m_arprot[2:0];
  assign s_RReady  = w_in_rd & m_RReady[w_sel];

  assign s_AWvalid = w_in_wr & m_AWvalid[w_sel] & ~aw_done_q;
  assign s_AWdata  = w_sel ? m_AWdata[63:32] : m_AWdata[31:0];
  assign s_awprot  = w_sel ? m_awprot[5:3]   : m_awprot[2:0];
  assign s_Wvalid  = w_in_wr & m_Wvalid[w_sel] & ~w_done_q;
  assign s_Wdata   = w_sel ? m_Wdata[63:32]  : m_Wdata[31:0];
  assign s_Wstrb   = w_sel ? m_Wstrb[7:4]    : m_Wstrb[3:0];
  assign s_Bready  = w_in_wr & w_b_ok & m_Bready[w_sel];

  assign m_Rdata     = w_in_tout ? ERR_DATA : s_Rdata;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = w_wd_hit;

  always_comb begin
    m_ARready = 2'b00;
    m_Rvalid  = 2'b00;
    m_AWready = 2'b00;
    m_Wready  = 2'b00;
    m_Bvalid  = 2'b00;
    m_ARready[w_sel] = w_in_rd & s_ARready & ~ar_done_q;
    m_Rvalid[w_sel]  = (w_in_rd & s_Rvalid) | (w_in_tout & tout_rd_q);
    m_AWready[w_sel] = w_in_wr & s_AWready & ~aw_done_q;
    m_Wready[w_sel]  = w_in_wr & s_Wready & ~w_done_q;
    m_Bvalid[w_sel]  = (w_in_wr & w_b_ok & s_Bvalid) | (w_in_tout & ~tout_rd_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      tout_rd_q <= 1'b0;
      wcnt_q    <= '0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|w_req) begin
            owner_q   <= w_win;
            last_q    <= w_win;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wcnt_q    <= '0;
            grant_q   <= w_win ? 2'b10 : 2'b01;
            busy_q    <= 1'b1;
            state_q   <= w_wr_req[w_win] ? S_WR : S_RD;
          end
        end
        S_RD: begin
          wcnt_q <= wcnt_q + 1'b1;
          if (w_ar_hs) ar_done_q <= 1'b1;
          if (w_rd_cpl) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else if (w_wd_hit) begin
            state_q   <= S_TOUT;
            tout_rd_q <= 1'b1;
          end
        end
        S_WR: begin
          wcnt_q <= wcnt_q + 1'b1;
          if (w_aw_hs) aw_done_q <= 1'b1;
          if (w_w_hs)  w_done_q  <= 1'b1;
          if (w_wr_cpl) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else if (w_wd_hit) begin
            state_q   <= S_TOUT;
            tout_rd_q <= 1'b0;
          end
        end
        S_TOUT: begin
          if (w_tout_cpl) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
